// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction RAM word loader
// Packs big-endian bytes into 32-bit words and holds the CPU until the image is complete.
module imem_loader #(
    parameter int          DEPTH     = 1001,
    parameter int          CNT_W     = 11,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [31:0]      checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam int               PAD_W   = 32 - CNT_W - 2;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] target_q,     target_d;
    logic [CNT_W-1:0] word_idx_q,   word_idx_d;
    logic [1:0]       byte_cnt_q,   byte_cnt_d;
    logic [31:0]      shreg_q,      shreg_d;
    logic             byte_ready_q, byte_ready_d;
    logic             imem_we_q,    imem_we_d;
    logic [31:0]      imem_addr_q,  imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             cpu_hold_q,   cpu_hold_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic             overflow_q,   overflow_d;
    logic [31:0]      checksum_q,   checksum_d;

    logic             xfer;
    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] idx_next;
    logic [31:0]      word_addr;

    assign xfer      = byte_valid & byte_ready_q;
    assign clamped   = (num_words > DEPTH_C) ? DEPTH_C : num_words;
    assign idx_next  = word_idx_q + CNT_W'(1);
    assign word_addr = BASE_ADDR + {{PAD_W{1'b0}}, word_idx_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        shreg_d      = shreg_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        overflow_d   = overflow_q;
        checksum_d   = checksum_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d   = clamped;
                    overflow_d = (num_words > DEPTH_C);
                    checksum_d = 32'h0;
                    word_idx_d = '0;
                    byte_cnt_d = 2'd0;
                    state_d    = (clamped == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (xfer) begin
                    shreg_d    = {shreg_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte: present the word to the RAM on the very next cycle.
                    if (byte_cnt_q == 2'd3) begin
                        state_d      = S_WRITE;
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {shreg_q[23:0], byte_in};
                        imem_addr_d  = word_addr;
                    end
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q + imem_wdata_q;
                byte_cnt_d = 2'd0;
                if (idx_next == target_q) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = idx_next;
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the next state, so none depend on byte_valid.
        byte_ready_d = (state_d == S_RECV);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
        cpu_hold_d   = busy_d;
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= 2'd0;
            shreg_q      <= 32'h0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'h0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            checksum_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shreg_q      <= shreg_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            checksum_q   <= checksum_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
// Expected RAM writes are queued by the stimulus and checked by an independent monitor.
module tb_imem_loader;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [31:0]      checksum;

    imem_loader #(.DEPTH(1001), .CNT_W(CNT_W), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .overflow(overflow),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_count = 0;
    int          hold_drops = 0;
    int          busy_seen = 0;
    bit          track_hold = 1'b0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                         imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (track_hold && !done && !cpu_hold) hold_drops++;
        if (busy === 1'b1) busy_seen++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            @(negedge clk);
            byte_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          we0;
        logic [31:0] sum;
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; num_words = '0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_byte_ready", {31'h0, byte_ready}, 32'h0);
        chk("rst_imem_we",    {31'h0, imem_we},    32'h0);
        chk("rst_imem_addr",  imem_addr,           32'h0);
        chk("rst_imem_wdata", imem_wdata,          32'h0);
        chk("rst_cpu_hold",   {31'h0, cpu_hold},   32'h0);
        chk("rst_busy",       {31'h0, busy},       32'h0);
        chk("rst_done",       {31'h0, done},       32'h0);
        chk("rst_overflow",   {31'h0, overflow},   32'h0);
        chk("rst_checksum",   checksum,            32'h0);

        // 1: two words, back-to-back bytes
        exp_q.push_back({32'h0000_0000, 32'h3C01_1001});
        exp_q.push_back({32'h0000_0004, 32'h3421_0004});
        do_start(11'd2);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        chk("t1_hold", {31'h0, cpu_hold}, 32'h1);
        send_word(32'h3C01_1001, 0);
        send_word(32'h3421_0004, 0);
        bus_idle();
        wait_done("t1_done");
        chk("t1_checksum", checksum, 32'h7022_1005);
        chk("t1_busy_after", {31'h0, busy}, 32'h0);

        // 2: same stream with 3 idle cycles between bytes
        we0 = we_count;
        exp_q.push_back({32'h0000_0000, 32'h3C01_1001});
        exp_q.push_back({32'h0000_0004, 32'h3421_0004});
        do_start(11'd2);
        chk("t2_done_cleared", {31'h0, done}, 32'h0);
        hold_drops = 0;
        track_hold = 1'b1;
        send_word(32'h3C01_1001, 3);
        send_word(32'h3421_0004, 3);
        bus_idle();
        wait_done("t2_done");
        track_hold = 1'b0;
        chk("t2_we_pulses", we_count - we0, 32'd2);
        chk("t2_hold_drops", hold_drops, 32'd0);
        chk("t2_checksum", checksum, 32'h7022_1005);

        // 3: zero-word load
        we0 = we_count;
        busy_seen = 0;
        do_start(11'd0);
        chk("t3_done", {31'h0, done}, 32'h1);
        repeat (3) @(negedge clk);
        chk("t3_busy_seen", busy_seen, 32'd0);
        chk("t3_no_we", we_count - we0, 32'd0);
        chk("t3_checksum", checksum, 32'h0);

        // 4: oversize request clamped to DEPTH
        we0 = we_count;
        sum = 32'h0;
        for (int i = 0; i < 1001; i++) begin
            w = 32'h1000_0000 + i * 32'h0001_0003;
            sum += w;
            exp_q.push_back({32'(i * 4), w});
        end
        do_start(11'd1002);
        for (int i = 0; i < 1001; i++) send_word(32'h1000_0000 + i * 32'h0001_0003, 0);
        bus_idle();
        wait_done("t4_done");
        chk("t4_writes", we_count - we0, 32'd1001);
        chk("t4_last_addr", imem_addr, 32'h0000_0FA0);
        chk("t4_overflow", {31'h0, overflow}, 32'h1);
        chk("t4_checksum", checksum, sum);
        we0 = we_count;
        @(negedge clk);
        byte_in = 8'h77; byte_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_extra_ready", {31'h0, byte_ready}, 32'h0);
        chk("t4_extra_no_we", we_count - we0, 32'd0);
        bus_idle();

        // 5: reset discards a partial word
        we0 = we_count;
        do_start(11'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        bus_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_ready", {31'h0, byte_ready}, 32'h0);
        chk("t5_rst_overflow", {31'h0, overflow}, 32'h0);
        chk("t5_rst_addr", imem_addr, 32'h0);
        exp_q.push_back({32'h0000_0000, 32'hAABB_CCDD});
        do_start(11'd1);
        send_word(32'hAABB_CCDD, 0);
        bus_idle();
        wait_done("t5_done");
        chk("t5_writes", we_count - we0, 32'd1);

        // 6: start ignored while busy; start in DONE restarts at BASE_ADDR
        we0 = we_count;
        exp_q.push_back({32'h0000_0000, 32'h3C01_1001});
        exp_q.push_back({32'h0000_0004, 32'h3421_0004});
        do_start(11'd2);
        send_byte(8'h3C, 0);
        send_byte(8'h01, 0);
        bus_idle();
        do_start(11'd5);
        chk("t6_busy_kept", {31'h0, busy}, 32'h1);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        send_word(32'h3421_0004, 0);
        bus_idle();
        wait_done("t6_done");
        chk("t6_writes", we_count - we0, 32'd2);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        do_start(11'd1);
        chk("t6_restart_done", {31'h0, done}, 32'h0);
        chk("t6_restart_busy", {31'h0, busy}, 32'h1);
        send_word(32'hDEAD_BEEF, 0);
        bus_idle();
        wait_done("t6_done2");
        chk("t6_checksum", checksum, 32'hDEAD_BEEF);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
